systolic_feeder: RTL and testbench
==================================

Name: systolic_feeder

Overview:
- Drives the top and left edges of the SIZE x SIZE weight-stationary systolic PE array.
- Buffers one weight tile and one activation tile written by the host.
- Shifts the weights down the columns while the weight-valid line is asserted.
- Then streams the activation vectors into the rows with a diagonal skew, zero-padding the fill and drain cycles.

Parameters:
- SIZE, 8, array dimension; also the number of bytes per weight row and per activation vector.
- DEPTH, 16, activation buffer depth in vectors.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- W_wr_en  input  1  write one weight row into the buffer; ignored while Busy
- W_wr_addr  input  $clog2(SIZE)  destination array row of the written weights
- W_wr_data  input  8*SIZE  bits [8j+7:8j] are the weight for column j
- A_wr_en  input  1  write one activation vector; ignored while Busy
- A_wr_addr  input  $clog2(DEPTH)  vector index
- A_wr_data  input  8*SIZE  bits [8i+7:8i] are the activation for array row i
- Start  input  1  launch a tile; accepted only in IDLE
- Num_Vec  input  $clog2(DEPTH+1)  vectors to stream, sampled with Start; values above DEPTH are clamped to DEPTH
- Reuse_W  input  1  sampled with Start; 1 skips weight loading
- Weight_out  output  8*SIZE  top edge of the array, column j in bits [8j+7:8j]
- Weight_out_valid  output  1  to the top-row Weight_in_valid lines
- Activation_out  output  8*SIZE  left edge of the array, row i in bits [8i+7:8i]
- Busy  output  1  high in every state except IDLE
- Done  output  1  one-cycle pulse at tile completion

Behaviour:
- Reset: all outputs 0 and state IDLE, applied immediately and asynchronously. Buffer RAMs are not reset; the host reloads them. Reset mid-operation aborts the tile and no Done is issued.
- All outputs are registered.
- States: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE -> LOAD_W on Start when Reuse_W=0; IDLE -> STREAM on Start when Reuse_W=1.
- Start asserted while Busy is ignored, as are buffer writes while Busy.
- LOAD_W lasts exactly SIZE cycles.
  - Weight_out_valid=1 throughout; Activation_out=0.
  - Cycle c (0..SIZE-1) drives weight buffer row SIZE-1-c, so after SIZE shifts array row r holds buffer row r.
  - Weight_out_valid first goes high in the cycle after the Start edge.
  - If Num_Vec=0, LOAD_W -> DONE.
- STREAM lasts Num_Vec+SIZE-1 cycles, counted by t.
  - Weight_out_valid=0; Weight_out holds 0.
  - Activation_out row i = A_buf[t-i] byte i when 0 <= t-i < Num_Vec, else 0.
  - The skew is implemented with per-row delay registers (row i delayed i cycles) fed from one buffer read per cycle.
  - If Num_Vec=0 with Reuse_W=1, IDLE goes directly to DONE.
- DRAIN lasts exactly SIZE cycles with Activation_out=0. This lets the last partial sums leave the bottom row.
- DONE lasts 1 cycle: Done=1 and Busy=1, then IDLE with Busy=0.
- Start may be asserted in the cycle right after DONE.
- Arithmetic: bytes are passed through without interpretation; signed handling happens in the PEs.
- Counter widths: at least $clog2(DEPTH+SIZE) bits. The Num_Vec clamp prevents wrap.

Test Plan:
1. Weight load ordering. SIZE=4; weight rows 0..3 = {0x01..}, {0x11..}, {0x21..}, {0x31..}; Start with Reuse_W=0, Num_Vec=1 -> Weight_out_valid high exactly 4 cycles, driving rows 3,2,1,0 in that order. Then Activation_out row i carries A_buf[0] byte i at stream cycle i, Done at cycle 4+4+4 after Start, Busy low the next cycle.
2. Skew and pad. SIZE=4, Num_Vec=3, A_buf[v] byte i = 16v+i -> STREAM lasts 6 cycles. Row 2 shows 0, 0, 0x02, 0x12, 0x22, 0; row 0 shows 0x00, 0x10, 0x20, 0, 0, 0. DRAIN shows all zero.
3. Reuse_W=1, Num_Vec=2 -> Weight_out_valid never asserted; STREAM starts the cycle after Start; Done after 2+3+4 cycles.
4. Busy protection. Mid-STREAM pulse Start and write A_buf[0]=0xFF.. -> no restart; current stream bytes unchanged; the next tile reads the old A_buf[0].
5. Reset mid-stream. Drop rst_n at STREAM cycle 2 -> all outputs 0 immediately and no Done. After release, a Start with previously written buffers replays correctly.
6. Edge counts. Num_Vec=0 with Reuse_W=0 -> 4 LOAD_W cycles then Done. Num_Vec=DEPTH+3 -> clamped to DEPTH; STREAM lasts DEPTH+SIZE-1 cycles.

Source files
------------

// File: rtl/systolic_feeder.sv
// systolic_feeder: edge driver for a SIZE x SIZE weight-stationary systolic array.
// Buffers one weight tile and one activation tile written by the host. On Start it
// shifts the weight rows down the columns (bottom row first), then streams the
// activation vectors into the rows with a diagonal skew and zero fill/drain.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   W_wr_en/W_wr_addr/W_wr_data    weight row write (ignored while Busy)
//   A_wr_en/A_wr_addr/A_wr_data    activation vector write (ignored while Busy)
//   Start, Num_Vec, Reuse_W        tile launch, vector count (clamped), skip weight load
//   Weight_out, Weight_out_valid   top edge of the array
//   Activation_out                 left edge of the array, row i in bits [8i+7:8i]
//   Busy, Done                     not-idle flag, one-cycle completion pulse
// SIZE must be at least 2.
module systolic_feeder #(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       W_wr_en,
  input  logic [$clog2(SIZE)-1:0]    W_wr_addr,
  input  logic [8*SIZE-1:0]          W_wr_data,
  input  logic                       A_wr_en,
  input  logic [$clog2(DEPTH)-1:0]   A_wr_addr,
  input  logic [8*SIZE-1:0]          A_wr_data,
  input  logic                       Start,
  input  logic [$clog2(DEPTH+1)-1:0] Num_Vec,
  input  logic                       Reuse_W,
  output logic [8*SIZE-1:0]          Weight_out,
  output logic                       Weight_out_valid,
  output logic [8*SIZE-1:0]          Activation_out,
  output logic                       Busy,
  output logic                       Done
);

  localparam int unsigned WAddrW  = $clog2(SIZE);
  localparam int unsigned AAddrW  = $clog2(DEPTH);
  localparam int unsigned NumVecW = $clog2(DEPTH + 1);
  localparam int unsigned CntW    = $clog2(DEPTH + SIZE + 1);

  typedef enum logic [2:0] {StIdle, StLoadW, StStream, StDrain, StDone} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [NumVecW-1:0]   num_vec_q, num_vec_d;
  logic [NumVecW-1:0]   nv_clamped;
  logic [CntW-1:0]      stream_last;

  logic [8*SIZE-1:0]    weight_out_q, weight_out_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [8*SIZE-1:0]    feed_d;
  logic [WAddrW-1:0]    w_idx;

  logic [8*SIZE-1:0]    w_buf [SIZE];
  logic [8*SIZE-1:0]    a_buf [DEPTH];

  // Buffers are not reset; writes are only honoured while idle.
  always_ff @(posedge clk) begin
    if (W_wr_en && !busy_q) w_buf[W_wr_addr] <= W_wr_data;
    if (A_wr_en && !busy_q) a_buf[A_wr_addr] <= A_wr_data;
  end

  assign nv_clamped  = (Num_Vec > NumVecW'(DEPTH)) ? NumVecW'(DEPTH) : Num_Vec;
  // STREAM runs Num_Vec + SIZE - 1 cycles, so its last count is Num_Vec + SIZE - 2.
  assign stream_last = CntW'(num_vec_q) + CntW'(SIZE - 2);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    num_vec_d = num_vec_q;
    case (state_q)
      StIdle: begin
        if (Start) begin
          num_vec_d = nv_clamped;
          cnt_d     = '0;
          if (!Reuse_W)              state_d = StLoadW;
          else if (nv_clamped == '0) state_d = StDone;
          else                       state_d = StStream;
        end
      end
      StLoadW: begin
        if (cnt_q == CntW'(SIZE - 1)) begin
          cnt_d   = '0;
          state_d = (num_vec_q == '0) ? StDone : StStream;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStream: begin
        if (cnt_q == stream_last) begin
          cnt_d   = '0;
          state_d = StDrain;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        if (cnt_q == CntW'(SIZE - 1)) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    w_idx        = WAddrW'(SIZE - 1) - cnt_d[WAddrW-1:0];
    weight_out_d = (state_d == StLoadW) ? w_buf[w_idx] : '0;
    valid_d      = (state_d == StLoadW);
    busy_d       = (state_d != StIdle);
    done_d       = (state_d == StDone);
    // One buffer read per cycle; the per-row delay lines below provide the skew.
    feed_d       = '0;
    if (state_d == StStream && cnt_d < CntW'(num_vec_d)) begin
      feed_d = a_buf[cnt_d[AAddrW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      num_vec_q    <= '0;
      weight_out_q <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      num_vec_q    <= num_vec_d;
      weight_out_q <= weight_out_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Row i sees the feed i cycles late through a chain of i+1 registers (the last is the output).
  // Zero feed outside STREAM flushes the chains, so DRAIN presents zeros.
  for (genvar i = 0; i < SIZE; i++) begin : g_row
    logic [7:0] dly_q [i+1];
    logic [7:0] dly_d [i+1];

    always_comb begin
      dly_d[0] = feed_d[8*i +: 8];
      for (int k = 1; k <= i; k++) begin
        dly_d[k] = dly_q[k-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k <= i; k++) begin
          dly_q[k] <= '0;
        end
      end else begin
        dly_q <= dly_d;
      end
    end

    assign Activation_out[8*i +: 8] = dly_q[i];
  end

  assign Weight_out       = weight_out_q;
  assign Weight_out_valid = valid_q;
  assign Busy             = busy_q;
  assign Done             = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder at SIZE=4, DEPTH=16.
module tb_systolic_feeder;

  localparam int SIZE  = 4;
  localparam int DEPTH = 16;

  logic        clk;
  logic        rst_n;
  logic        W_wr_en;
  logic [1:0]  W_wr_addr;
  logic [31:0] W_wr_data;
  logic        A_wr_en;
  logic [3:0]  A_wr_addr;
  logic [31:0] A_wr_data;
  logic        Start;
  logic [4:0]  Num_Vec;
  logic        Reuse_W;
  logic [31:0] Weight_out;
  logic        Weight_out_valid;
  logic [31:0] Activation_out;
  logic        Busy;
  logic        Done;

  systolic_feeder #(
    .SIZE  (SIZE),
    .DEPTH (DEPTH)
  ) u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .W_wr_en          (W_wr_en),
    .W_wr_addr        (W_wr_addr),
    .W_wr_data        (W_wr_data),
    .A_wr_en          (A_wr_en),
    .A_wr_addr        (A_wr_addr),
    .A_wr_data        (A_wr_data),
    .Start            (Start),
    .Num_Vec          (Num_Vec),
    .Reuse_W          (Reuse_W),
    .Weight_out       (Weight_out),
    .Weight_out_valid (Weight_out_valid),
    .Activation_out   (Activation_out),
    .Busy             (Busy),
    .Done             (Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec;
  int          n_err;
  logic [31:0] a_mem [DEPTH];
  logic [7:0]  row0_seq [8];
  logic [7:0]  row2_seq [8];
  logic [7:0]  exp_row0 [6];
  logic [7:0]  exp_row2 [6];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Weight row r, column j holds 16r + j + 1.
  function automatic logic [31:0] wrow(input int r);
    logic [31:0] v;
    for (int j = 0; j < SIZE; j++) v[8*j +: 8] = 8'(16 * r + j + 1);
    return v;
  endfunction

  // Left edge at stream cycle t: row i carries vector t-i when it is in range.
  function automatic logic [31:0] exp_act(input int t, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (t - i >= 0 && t - i < n) r[8*i +: 8] = a_mem[t-i][8*i +: 8];
    end
    return r;
  endfunction

  task automatic write_w(input int r, input logic [31:0] d);
    W_wr_en = 1'b1; W_wr_addr = 2'(r); W_wr_data = d;
    step();
    W_wr_en = 1'b0;
  endtask

  task automatic write_a(input int a, input logic [31:0] d);
    A_wr_en = 1'b1; A_wr_addr = 4'(a); A_wr_data = d;
    step();
    A_wr_en = 1'b0;
  endtask

  // Launches a tile and checks every cycle through to the idle cycle after Done.
  // inject >= 0 pulses Start and an A_buf[0] write at that stream cycle.
  task automatic run_tile(input int nv, input bit reuse, input int inject);
    int nve;
    nve     = (nv > DEPTH) ? DEPTH : nv;
    Num_Vec = 5'(nv);
    Reuse_W = reuse;
    Start   = 1'b1;
    step();
    Start   = 1'b0;
    if (!reuse) begin
      for (int c = 0; c < SIZE; c++) begin
        check("ld_valid", 32'(Weight_out_valid), 32'd1);
        check("ld_weight", Weight_out, wrow(SIZE - 1 - c));
        check("ld_act", Activation_out, 32'd0);
        check("ld_busy", 32'(Busy), 32'd1);
        check("ld_done", 32'(Done), 32'd0);
        step();
      end
    end
    if (nve != 0) begin
      for (int t = 0; t < nve + SIZE - 1; t++) begin
        if (t < 8) begin
          row0_seq[t] = Activation_out[7:0];
          row2_seq[t] = Activation_out[23:16];
        end
        check("st_valid", 32'(Weight_out_valid), 32'd0);
        check("st_weight", Weight_out, 32'd0);
        check("st_act", Activation_out, exp_act(t, nve));
        check("st_busy", 32'(Busy), 32'd1);
        check("st_done", 32'(Done), 32'd0);
        if (t == inject) begin
          Start = 1'b1; A_wr_en = 1'b1; A_wr_addr = 4'd0; A_wr_data = 32'hFFFF_FFFF;
        end
        step();
        Start = 1'b0; A_wr_en = 1'b0;
      end
      for (int d = 0; d < SIZE; d++) begin
        check("dr_act", Activation_out, 32'd0);
        check("dr_valid", 32'(Weight_out_valid), 32'd0);
        check("dr_busy", 32'(Busy), 32'd1);
        check("dr_done", 32'(Done), 32'd0);
        step();
      end
    end
    check("dn_done", 32'(Done), 32'd1);
    check("dn_busy", 32'(Busy), 32'd1);
    check("dn_valid", 32'(Weight_out_valid), 32'd0);
    step();
    check("idle_busy", 32'(Busy), 32'd0);
    check("idle_done", 32'(Done), 32'd0);
    check("idle_act", Activation_out, 32'd0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0;
    W_wr_en = 1'b0; W_wr_addr = '0; W_wr_data = '0;
    A_wr_en = 1'b0; A_wr_addr = '0; A_wr_data = '0;
    Start = 1'b0; Num_Vec = '0; Reuse_W = 1'b0;
    exp_row0 = '{8'h00, 8'h10, 8'h20, 8'h00, 8'h00, 8'h00};
    exp_row2 = '{8'h00, 8'h00, 8'h02, 8'h12, 8'h22, 8'h00};

    #12;
    check("rst_weight", Weight_out, 32'd0);
    check("rst_valid", 32'(Weight_out_valid), 32'd0);
    check("rst_act", Activation_out, 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    rst_n = 1'b1;
    step();

    for (int r = 0; r < SIZE; r++) write_w(r, wrow(r));
    for (int v = 0; v < DEPTH; v++) begin
      for (int i = 0; i < SIZE; i++) a_mem[v][8*i +: 8] = 8'(16 * v + i);
      write_a(v, a_mem[v]);
    end

    // Weight load order, one vector.
    run_tile(1, 1'b0, -1);

    // Skew and zero padding, hand-listed edge bytes.
    run_tile(3, 1'b1, -1);
    for (int t = 0; t < 6; t++) begin
      check("skew_row0", 32'(row0_seq[t]), 32'(exp_row0[t]));
      check("skew_row2", 32'(row2_seq[t]), 32'(exp_row2[t]));
    end

    // Reuse weights.
    run_tile(2, 1'b1, -1);

    // Start and buffer write while busy are ignored; next tile sees the old A_buf[0].
    run_tile(3, 1'b1, 1);
    run_tile(3, 1'b1, -1);

    // Reset mid-stream.
    Num_Vec = 5'd3; Reuse_W = 1'b1; Start = 1'b1;
    step();
    Start = 1'b0;
    step();
    step();
    check("pre_rst_act", Activation_out, exp_act(2, 3));
    rst_n = 1'b0;
    #1;
    check("mid_rst_act", Activation_out, 32'd0);
    check("mid_rst_busy", 32'(Busy), 32'd0);
    check("mid_rst_done", 32'(Done), 32'd0);
    check("mid_rst_weight", Weight_out, 32'd0);
    check("mid_rst_valid", 32'(Weight_out_valid), 32'd0);
    step();
    check("rst_hold_done", 32'(Done), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("post_rst_done", 32'(Done), 32'd0);
      check("post_rst_busy", 32'(Busy), 32'd0);
    end
    run_tile(3, 1'b0, -1);

    // Edge counts: empty tiles and clamped count.
    run_tile(0, 1'b0, -1);
    run_tile(0, 1'b1, -1);
    run_tile(DEPTH + 3, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
